// File: rtl/snn_pkg.sv
// Shared defaults, FSM state encoding and synaptic weight table for the LIF spiking core.
package snn_pkg;

  localparam int unsigned DEF_N_IN       = 16;
  localparam int unsigned DEF_N_OUT      = 8;
  localparam int unsigned DEF_V_W        = 16;
  localparam int unsigned DEF_W_W        = 8;
  localparam int          DEF_THRESH     = 32;
  localparam int unsigned DEF_LEAK_SHIFT = 3;

  localparam int unsigned IN_IW  = $clog2(DEF_N_IN);
  localparam int unsigned OUT_IW = $clog2(DEF_N_OUT);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    UPDATE = 2'd1,
    EMIT   = 2'd2
  } state_e;

  typedef logic [DEF_N_OUT-1:0][DEF_N_IN-1:0][DEF_W_W-1:0] weights_t;

  // Excitatory +8 from every eighth line onto its own neuron, -1 lateral inhibition otherwise.
  function automatic weights_t init_weights();
    weights_t w;
    w = '0;
    for (int unsigned k = 0; k < DEF_N_OUT; k++) begin
      for (int unsigned i = 0; i < DEF_N_IN; i++) begin
        w[OUT_IW'(k)][IN_IW'(i)] = ((i % 8) == k) ? DEF_W_W'(8) : DEF_W_W'(-1);
      end
    end
    return w;
  endfunction

  localparam weights_t WEIGHTS = init_weights();

endpackage

// File: rtl/snn_core_lif_update.sv
// Combinational LIF step for one neuron: weighted input sum, leak, saturation, threshold.
module lif_update
  import snn_pkg::*;
#(
  parameter int unsigned N_IN       = DEF_N_IN,
  parameter int unsigned V_W        = DEF_V_W,
  parameter int unsigned W_W        = DEF_W_W,
  parameter int          THRESH     = DEF_THRESH,
  parameter int unsigned LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int unsigned K_W        = OUT_IW
) (
  input  logic [N_IN-1:0]       spike,
  input  logic [K_W-1:0]        k,
  input  logic signed [V_W-1:0] v_in,
  output logic signed [V_W-1:0] v_next_c,
  output logic                  fire_c
);

  localparam int unsigned A_W = V_W + 4;
  localparam int unsigned IW  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic signed [A_W-1:0] V_MIN = A_W'(-4 * THRESH);
  localparam logic signed [A_W-1:0] V_MAX = A_W'((1 << (V_W - 1)) - 1);
  localparam logic signed [A_W-1:0] TH    = A_W'(THRESH);

  logic signed [W_W-1:0] w;
  logic signed [A_W-1:0] i_sum;
  logic signed [A_W-1:0] v_ext;
  logic signed [A_W-1:0] v_raw;
  logic signed [A_W-1:0] v_sat;

  always_comb begin
    w     = '0;
    i_sum = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      w = W_W'($signed(WEIGHTS[k][IW'(i)]));
      if (spike[IW'(i)]) i_sum = i_sum + A_W'(w);
    end
    v_ext = A_W'(v_in);
    v_raw = v_ext - (v_ext >>> LEAK_SHIFT) + i_sum;
    if (v_raw < V_MIN)      v_sat = V_MIN;
    else if (v_raw > V_MAX) v_sat = V_MAX;
    else                    v_sat = v_raw;
    fire_c   = (v_sat >= TH);
    v_next_c = fire_c ? '0 : V_W'(v_sat);
  end

endmodule

// File: rtl/snn_core.sv
// Self-paced LIF spiking layer: one timestep every N_OUT+2 cycles, one neuron updated per cycle.
module snn_core
  import snn_pkg::*;
#(
  parameter int unsigned N_IN       = DEF_N_IN,
  parameter int unsigned N_OUT      = DEF_N_OUT,
  parameter int unsigned V_W        = DEF_V_W,
  parameter int unsigned W_W        = DEF_W_W,
  parameter int          THRESH     = DEF_THRESH,
  parameter int unsigned LEAK_SHIFT = DEF_LEAK_SHIFT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_IN-1:0]  spike_i,
  output logic [N_OUT-1:0] spike_o,
  output logic             next_stage
);

  localparam int unsigned K_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  state_e                state;
  state_e                state_nxt;
  logic [K_W-1:0]        idx;
  logic [N_IN-1:0]       spike_q;
  logic [N_OUT-1:0]      shadow;
  logic [N_OUT-1:0]      shadow_c;
  logic signed [V_W-1:0] v_mem [N_OUT];
  logic signed [V_W-1:0] v_next_c;
  logic                  fire_c;

  lif_update #(
    .N_IN       (N_IN),
    .V_W        (V_W),
    .W_W        (W_W),
    .THRESH     (THRESH),
    .LEAK_SHIFT (LEAK_SHIFT),
    .K_W        (K_W)
  ) u_lif (
    .spike    (spike_q),
    .k        (idx),
    .v_in     (v_mem[idx]),
    .v_next_c (v_next_c),
    .fire_c   (fire_c)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    state_nxt = UPDATE;
      UPDATE:  if (idx == K_W'(N_OUT - 1)) state_nxt = EMIT;
      EMIT:    state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Shadow with the current neuron's fire bit merged, so the last neuron lands in spike_o.
  always_comb begin
    shadow_c      = shadow;
    shadow_c[idx] = fire_c;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      idx        <= '0;
      spike_q    <= '0;
      shadow     <= '0;
      spike_o    <= '0;
      next_stage <= 1'b0;
      v_mem      <= '{default: '0};
    end else begin
      next_stage <= (state_nxt == EMIT);
      case (state)
        LOAD: begin
          spike_q <= spike_i;
          idx     <= '0;
        end
        UPDATE: begin
          v_mem[idx] <= v_next_c;
          shadow     <= shadow_c;
          idx        <= idx + K_W'(1);
          if (state_nxt == EMIT) spike_o <= shadow_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_core.sv
// Self-checking bench for snn_core: spec-level timestep model, vector table and reset/isolation sequences.
module tb_snn_core;

  logic        clk_i;
  logic        rst_i;
  logic [15:0] spike_i;
  logic [7:0]  spike_o;
  logic        next_stage;

  int n_checks;
  int n_errors;

  int          mv [8];
  logic [7:0]  last_o;

  typedef struct {
    logic [15:0] spk;
    logic [7:0]  exp_o;
  } vec_t;

  vec_t tbl [9];

  snn_core dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .spike_i    (spike_i),
    .spike_o    (spike_o),
    .next_stage (next_stage)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
    n_checks++;
    if (got !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 8; k++) mv[k] = 0;
    last_o = 8'h00;
  endtask

  // One timestep of the layer, straight from the neuron equations in integer arithmetic.
  task automatic model_step(input logic [15:0] s, output logic [7:0] f);
    int cur;
    int vn;
    f = 8'h00;
    for (int k = 0; k < 8; k++) begin
      cur = 0;
      for (int i = 0; i < 16; i++) begin
        if (((s >> i) & 16'h0001) != 16'h0000) cur += ((i % 8) == k) ? 8 : -1;
      end
      vn = mv[k] - (mv[k] >>> 3) + cur;
      if (vn < -128)  vn = -128;
      if (vn > 32767) vn = 32767;
      if (vn >= 32) begin
        f     = f | (8'h01 << k);
        mv[k] = 0;
      end else begin
        mv[k] = vn;
      end
    end
  endtask

  // Entered before the edge that leaves LOAD; returns in the following LOAD cycle.
  task automatic timestep(input logic [15:0] spk, input logic [7:0] exp_o, input bit toggle,
                          input string tag);
    spike_i = spk;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk_i);
      #1;
      if (c <= 8) begin
        if (toggle) spike_i = 16'($urandom);
        chk({tag, " next_stage low in UPDATE"}, 32'(next_stage), 32'd0);
        chk({tag, " spike_o held in UPDATE"}, 32'(spike_o), 32'(last_o));
      end else if (c == 9) begin
        chk({tag, " next_stage in EMIT"}, 32'(next_stage), 32'd1);
        chk({tag, " spike_o in EMIT"}, 32'(spike_o), 32'(exp_o));
      end else begin
        chk({tag, " next_stage low in LOAD"}, 32'(next_stage), 32'd0);
        chk({tag, " spike_o held in LOAD"}, 32'(spike_o), 32'(exp_o));
      end
    end
    last_o = exp_o;
  endtask

  task automatic model_timestep(input logic [15:0] spk, input bit toggle, input string tag);
    logic [7:0] e;
    model_step(spk, e);
    timestep(spk, e, toggle, tag);
  endtask

  initial begin
    logic [7:0]  e;
    logic [15:0] r;
    bit          fired;

    n_checks = 0;
    n_errors = 0;
    spike_i  = 16'h0000;
    rst_i    = 1'b0;
    model_reset();

    repeat (3) @(posedge clk_i);
    #1;
    chk("reset spike_o", 32'(spike_o), 32'd0);
    chk("reset next_stage", 32'(next_stage), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    for (int t = 0; t < 20; t++) begin
      model_step(16'h0000, e);
      timestep(16'h0000, 8'h00, 1'b0, "silence");
    end

    tbl[0] = '{16'h0101, 8'h00};
    tbl[1] = '{16'h0101, 8'h00};
    tbl[2] = '{16'h0101, 8'h01};
    tbl[3] = '{16'h0101, 8'h00};
    tbl[4] = '{16'h0101, 8'h00};
    tbl[5] = '{16'h0101, 8'h01};
    tbl[6] = '{16'h0101, 8'h00};
    tbl[7] = '{16'h0101, 8'h00};
    tbl[8] = '{16'h0101, 8'h01};
    model_reset();
    for (int t = 0; t < 9; t++) begin
      model_step(tbl[t].spk, e);
      timestep(tbl[t].spk, tbl[t].exp_o, 1'b0, "firing table");
    end

    // Reset asserted in the middle of UPDATE while spike_o still shows a fire.
    spike_i = 16'h0101;
    repeat (4) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    chk("mid-update reset spike_o", 32'(spike_o), 32'd0);
    chk("mid-update reset next_stage", 32'(next_stage), 32'd0);
    repeat (5) @(posedge clk_i);
    #1;
    chk("reset held next_stage", 32'(next_stage), 32'd0);
    chk("reset held spike_o", 32'(spike_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    model_reset();

    for (int t = 0; t < 10; t++) begin
      model_step(16'hFFFF, e);
      timestep(16'hFFFF, 8'h00, 1'b0, "all-ones");
    end

    for (int t = 0; t < 200; t++) begin
      model_timestep(16'hFEFE, 1'b0, "inhibit");
      chk("inhibit spike_o[0]", 32'(spike_o[0]), 32'd0);
    end

    fired = 1'b0;
    for (int t = 0; t < 30 && !fired; t++) begin
      model_timestep(16'h0101, 1'b0, "recover");
      fired = spike_o[0];
    end
    chk("recover fires neuron 0", 32'(fired), 32'd1);

    for (int t = 0; t < 40; t++) begin
      r = 16'($urandom);
      model_timestep(r, 1'b1, "isolation toggled");
    end

    for (int t = 0; t < 20; t++) begin
      r = 16'($urandom) | 16'($urandom);
      model_timestep(r, 1'b0, "random held");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
